// File: rtl/fpu_dp_result_stage.sv
// Output stage for the double-precision add/sub datapath: classifies each result on capture,
// queues it in a small FIFO for writeback and keeps software-clearable sticky exception flags.
module fpu_dp_result_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [4:0]                 out_flags,
    output logic [4:0]                 sticky_flags,
    input  logic                       sticky_clear,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [4:0]        flags_q [DEPTH];
    logic [4:0]        flags_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        sticky_q, sticky_d;

    logic       push, pop;
    logic [10:0] exp_field;
    logic       man_zero, exp_ones, exp_zero;
    logic [4:0] push_flags;

    // Readiness comes from registered occupancy only, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign exp_field  = in_result[62:52];
    assign man_zero   = (in_result[51:0] == '0);
    assign exp_ones   = (exp_field == 11'h7FF);
    assign exp_zero   = (exp_field == 11'h000);
    // Datapath flags are kept verbatim alongside the class bits; sign is ignored.
    assign push_flags = {in_overflow, in_underflow, exp_ones & ~man_zero,
                         exp_ones & man_zero, exp_zero & man_zero};

    always_comb begin
        data_d   = data_q;
        flags_d  = flags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = (sticky_clear ? 5'b0 : sticky_q) | (push ? push_flags : 5'b0);

        if (push) begin
            data_d[wr_ptr_q]  = in_result;
            flags_d[wr_ptr_q] = push_flags;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                flags_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            data_q   <= data_d;
            flags_q  <= flags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_result   = data_q[rd_ptr_q];
    assign out_flags    = flags_q[rd_ptr_q];
    assign sticky_flags = sticky_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fpu_dp_result_stage.sv
// Bench for fpu_dp_result_stage: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the stage.
module tb_fpu_dp_result_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic        in_underflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        sticky_clear = 1'b0;
    logic [2:0]  count;

    fpu_dp_result_stage #(.DATA_W(64), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clear (sticky_clear),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  f;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] m_sticky = '0;
    bit         m_fresh  = 1'b0;
    int         n_cmp    = 0;
    int         n_err    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] classify(input logic [63:0] r, input bit ov, input bit un);
        longint unsigned e, m;
        bit nan, inf, zero;
        e    = (r >> 52) & 64'h7FF;
        m    = r & 64'h000F_FFFF_FFFF_FFFF;
        nan  = (e == 2047) && (m != 0);
        inf  = (e == 2047) && (m == 0);
        zero = (e == 0) && (m == 0);
        return {ov, un, nan, inf, zero};
    endfunction

    // Drive one cycle: compare outputs to the model before the edge, then advance the model.
    task automatic cycle(input bit r_st, input bit iv, input logic [63:0] res, input bit ov,
                         input bit un, input bit ordy, input bit sclr);
        bit   push, pop;
        ent_t e;
        rst = r_st; in_valid = iv; in_result = res; in_overflow = ov;
        in_underflow = un; out_ready = ordy; sticky_clear = sclr;
        @(negedge clk);
        check_eq("count", 64'(count), 64'(mq.size()));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        check_eq("sticky", 64'(sticky_flags), 64'(m_sticky));
        if (mq.size() != 0) begin
            check_eq("out_result", out_result, mq[0].r);
            check_eq("out_flags", 64'(out_flags), 64'(mq[0].f));
        end else if (m_fresh) begin
            check_eq("rst_result", out_result, 64'h0);
            check_eq("rst_flags", 64'(out_flags), 64'h0);
        end
        @(posedge clk);
        if (r_st) begin
            mq.delete();
            m_sticky = '0;
            m_fresh  = 1'b1;
        end else begin
            push = iv && (mq.size() < DEPTH);
            pop  = ordy && (mq.size() != 0);
            e.r  = res;
            e.f  = classify(res, ov, un);
            m_sticky = (sclr ? 5'b0 : m_sticky) | (push ? e.f : 5'b0);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                m_fresh = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: w = {w[63], 63'h0};
            1: w = {w[63], 11'h7FF, 52'h0};
            2: w = {w[63], 11'h7FF, w[51:1], 1'b1};
            3: w = {w[63], 11'h7FF, w[51:0]};
            4: w = {w[63], 11'h000, w[51:0]};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        // Reset state
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_count", 64'(count), 64'h0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h1);
        check_eq("rst_out_result", out_result, 64'h0);

        // Normal word, one cycle latency
        cycle(1'b0, 1'b1, 64'h4000000000000000, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t1_valid", 64'(out_valid), 64'h1);
        check_eq("t1_result", out_result, 64'h4000000000000000);
        check_eq("t1_flags", 64'(out_flags), 64'h0);
        check_eq("t1_count", 64'(count), 64'h1);
        idle(1'b1);

        // Infinity with overflow
        cycle(1'b0, 1'b1, 64'h7FF0000000000000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t2_flags", 64'(out_flags), 64'h12);
        check_eq("t2_sticky", 64'(sticky_flags), 64'h12);
        idle(1'b1);

        // Fill, hold a fifth word, then pop-only while full
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 64'h3FF0000000000000 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_in_ready", 64'(in_ready), 64'h0);
        check_eq("t3_count", 64'(count), 64'h4);
        cycle(1'b0, 1'b1, 64'h3FF00000000000AA, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_held_count", 64'(count), 64'h4);
        cycle(1'b0, 1'b1, 64'h3FF00000000000AA, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t4_count", 64'(count), 64'h3);
        check_eq("t4_in_ready", 64'(in_ready), 64'h1);
        check_eq("t4_head", out_result, 64'h3FF0000000000001);
        cycle(1'b0, 1'b1, 64'h3FF00000000000AA, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b1);

        // Clear coinciding with a NaN push
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 64'h3FF0000000000000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t5_sticky_pre", 64'(sticky_flags), 64'h10);
        cycle(1'b0, 1'b1, 64'h7FF8000000000000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("t5_sticky", 64'(sticky_flags), 64'h04);
        idle(1'b1);

        // Reset with stored entries, then negative zero
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 64'h7FF0000000000000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_valid", 64'(out_valid), 64'h0);
        check_eq("t6_count", 64'(count), 64'h0);
        check_eq("t6_sticky", 64'(sticky_flags), 64'h0);
        check_eq("t6_in_ready", 64'(in_ready), 64'h1);
        cycle(1'b0, 1'b1, 64'h8000000000000000, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_flags", 64'(out_flags), 64'h01);
        idle(1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60), rand_word(),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
